rah_tx_gearbox: RTL and testbench



---
 rtl/rah_tx_gearbox.sv | 110 +++++++++++
 tb/tb_rah_tx_gearbox.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rah_tx_gearbox.sv
// rah_tx_gearbox: packs DATA_WIDTH-bit packets back-to-back into MIPI_WIDTH-bit
// words for the MIPI TX data bus. The first packet lands in the LSBs and later
// packets continue little-endian. A packet flagged in_last flushes the
// remaining bits as a zero-padded word.
// Optional: define RAH_TX_GEARBOX_STATS_EN to add the word_count/pad_count ports.
// DATA_WIDTH must be a multiple of 16 and less than MIPI_WIDTH. MIPI_WIDTH must
// be a multiple of 16.
module rah_tx_gearbox #(
    parameter int DATA_WIDTH = 48,
    parameter int MIPI_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [MIPI_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef RAH_TX_GEARBOX_STATS_EN
    ,
    output logic [31:0]           word_count,
    output logic [15:0]           pad_count
`endif
);

    localparam int BUF_W  = DATA_WIDTH + MIPI_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] MIPI_FILL = FILL_W'(MIPI_WIDTH);
    localparam logic [FILL_W-1:0] DATA_FILL = FILL_W'(DATA_WIDTH);

    // Bits at or above fill_reg are always zero. The pop shift and the OR-insert
    // rely on this, so no masking is needed.
    logic [BUF_W-1:0]  buf_reg, buf_next, buf_popped;
    logic [FILL_W-1:0] fill_reg, fill_next, fill_popped;
    logic              flush_reg, flush_next;
    logic              acc, pop;

    // in_ready depends only on the registered state and rst. It has no path
    // from out_ready. Input stops once a full word plus a partial word is queued.
    assign in_ready  = !rst && !flush_reg && (fill_reg <= MIPI_FILL);
    assign out_valid = (fill_reg >= MIPI_FILL) || (flush_reg && (fill_reg != '0));
    assign out_data  = buf_reg[MIPI_WIDTH-1:0];

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // Next state: the pop is applied first. The accepted packet is then
    // inserted at the post-pop fill position.
    always_comb begin
        buf_popped  = buf_reg;
        fill_popped = fill_reg;
        if (pop) begin
            buf_popped  = buf_reg >> MIPI_WIDTH;
            // A flushed partial word pops fewer than MIPI_WIDTH bits, so fill
            // saturates at zero.
            fill_popped = (fill_reg >= MIPI_FILL) ? (fill_reg - MIPI_FILL) : '0;
        end

        buf_next   = buf_popped;
        fill_next  = fill_popped;
        flush_next = flush_reg;
        if (acc) begin
            buf_next   = buf_popped | (BUF_W'(in_data) << fill_popped);
            fill_next  = fill_popped + DATA_FILL;
            // acc can only happen while flush_reg is clear, so in_last alone
            // decides the new flag.
            flush_next = in_last;
        end else if (flush_reg && (fill_popped == '0)) begin
            flush_next = 1'b0;
        end
    end

    // State register. Reset discards any buffered partial data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_reg   <= '0;
            fill_reg  <= '0;
            flush_reg <= 1'b0;
        end else begin
            buf_reg   <= buf_next;
            fill_reg  <= fill_next;
            flush_reg <= flush_next;
        end
    end

`ifdef RAH_TX_GEARBOX_STATS_EN
    logic [31:0] word_count_reg;
    logic [15:0] pad_count_reg;

    // Output statistics. A padded word is a pop of a flushed partial word.
    // Both counters wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_reg <= '0;
            pad_count_reg  <= '0;
        end else if (pop) begin
            word_count_reg <= word_count_reg + 32'd1;
            if (flush_reg && (fill_reg < MIPI_FILL)) begin
                pad_count_reg <= pad_count_reg + 16'd1;
            end
        end
    end

    assign word_count = word_count_reg;
    assign pad_count  = pad_count_reg;
`endif

endmodule

// File: tb/tb_rah_tx_gearbox.sv
// Bench for rah_tx_gearbox. A bit-queue model predicts in_ready, out_valid and
// out_data on every cycle. Popped words are also logged and compared against
// hand-packed literal words.
module tb_rah_tx_gearbox;

    localparam int DW = 48;
    localparam int MW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [MW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef RAH_TX_GEARBOX_STATS_EN
    logic [31:0]   word_count;
    logic [15:0]   pad_count;
`endif

    rah_tx_gearbox #(.DATA_WIDTH(DW), .MIPI_WIDTH(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RAH_TX_GEARBOX_STATS_EN
        ,
        .word_count(word_count),
        .pad_count (pad_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: the pending bit stream (index 0 is the next bit out) and the flush flag.
    bit            mq[$];
    bit            m_flush = 1'b0;
    int            m_acc_cnt = 0;
    logic [MW-1:0] wlog[$];

    function automatic bit m_valid();
        return (mq.size() >= MW) || (m_flush && (mq.size() != 0));
    endfunction

    function automatic bit m_ready();
        return !rst && !m_flush && (mq.size() <= MW);
    endfunction

    function automatic logic [MW-1:0] m_word();
        logic [MW-1:0] w;
        for (int i = 0; i < MW; i++) w[i] = (i < mq.size()) ? mq[i] : 1'b0;
        return w;
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge. Reset empties the stream at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_flush = 1'b0;
        end else begin
            bit pop;
            bit acc;
            pop = m_valid() && out_ready;
            acc = in_valid && m_ready();
            if (pop) repeat (MW) if (mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                for (int i = 0; i < DW; i++) mq.push_back(in_data[i]);
                m_acc_cnt++;
                if (in_last) m_flush = 1'b1;
            end else if (m_flush && (mq.size() == 0)) begin
                m_flush = 1'b0;
            end
        end
    end

    // Per-cycle comparison of all outputs. Words about to be popped are logged.
    always @(negedge clk) begin
        check("in_ready", MW'(in_ready), MW'(m_ready()));
        check("out_valid", MW'(out_valid), MW'(m_valid()));
        check("out_data", out_data, m_word());
        if (m_valid() && out_ready && !rst) wlog.push_back(out_data);
    end

    function automatic logic [MW-1:0] logw(input int i);
        return (i < wlog.size()) ? wlog[i] : {MW{1'bx}};
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 60) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mq.size() == 0 && !m_flush) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", MW'(done), 1);
    endtask

    localparam logic [DW-1:0] P0 = 48'h010203040506;
    localparam logic [DW-1:0] P1 = 48'h111213141516;
    localparam logic [DW-1:0] P2 = 48'h212223242526;
    localparam logic [DW-1:0] P3 = 48'h313233343536;
    localparam logic [MW-1:0] W0 = 64'h1516010203040506;
    localparam logic [MW-1:0] W1 = 64'h2324252611121314;
    localparam logic [MW-1:0] W2 = 64'h3132333435362122;

    initial begin
        logic [DW-1:0] pk[12];
        logic [MW-1:0] ref_w[9];
        int            acc0;
`ifdef RAH_TX_GEARBOX_STATS_EN
        logic [15:0]   pad0;
`endif
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", MW'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", MW'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Steady 4-packet stream.
        wlog.delete();
        send(P0, 0); send(P1, 0); send(P2, 0); send(P3, 0);
        repeat (6) @(negedge clk);
        check("t1_count", wlog.size(), 3);
        check("t1_w0", logw(0), W0);
        check("t1_w1", logw(1), W1);
        check("t1_w2", logw(2), W2);
        check("t1_empty", MW'(out_valid), 0);

        // Single packet with in_last.
        @(posedge clk); #1;
        wlog.delete();
`ifdef RAH_TX_GEARBOX_STATS_EN
        pad0 = pad_count;
`endif
        send(P0, 1);
        drain();
        check("t2_count", wlog.size(), 1);
        check("t2_w0", logw(0), 64'h0000010203040506);
        check("t2_ready_after", MW'(in_ready), 1);
`ifdef RAH_TX_GEARBOX_STATS_EN
        check("t2_pad_count", MW'(pad_count - pad0), 1);
`endif

        // Two packets, last on the second one.
        @(posedge clk); #1;
        wlog.delete();
        send(P0, 0); send(P1, 1);
        drain();
        check("t3_count", wlog.size(), 2);
        check("t3_w0", logw(0), W0);
        check("t3_w1", logw(1), 64'h0000000011121314);

        // Backpressure.
        @(posedge clk); #1;
        wlog.delete();
        out_ready = 1'b0;
        acc0 = m_acc_cnt;
        send(P0, 0); send(P1, 0);
        in_data = P2; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_accepted", MW'(m_acc_cnt - acc0), 2);
        check("t4_in_ready", MW'(in_ready), 0);
        check("t4_hold_data", out_data, W0);
        check("t4_hold_valid", MW'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(P2, 0); send(P3, 1);
        drain();
        check("t4_count", wlog.size(), 3);
        check("t4_w0", logw(0), W0);
        check("t4_w1", logw(1), W1);
        check("t4_w2", logw(2), W2);

        // 12-packet continuous stream, packed by hand per group of four.
        for (int i = 0; i < 12; i++) pk[i] = 48'hA0B0C0D0E0F0 ^ (48'(i) * 48'h010101010101);
        for (int g = 0; g < 3; g++) begin
            ref_w[3*g]   = {pk[4*g+1][15:0], pk[4*g]};
            ref_w[3*g+1] = {pk[4*g+2][31:0], pk[4*g+1][47:16]};
            ref_w[3*g+2] = {pk[4*g+3], pk[4*g+2][47:32]};
        end
        @(posedge clk); #1;
        wlog.delete();
        for (int i = 0; i < 12; i++) send(pk[i], (i == 11) ? 1'b1 : 1'b0);
        drain();
        check("t5_count", wlog.size(), 9);
        for (int i = 0; i < 9; i++) check($sformatf("t5_w%0d", i), logw(i), ref_w[i]);

        // Reset mid-operation.
        @(posedge clk); #1;
        send(P0, 0); send(P1, 0); send(P2, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", MW'(out_valid), 0);
        check("t6_rst_ready", MW'(in_ready), 0);
        @(negedge clk);
        check("t6_rst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wlog.delete();
        send(P0, 1);
        drain();
        check("t6_count", wlog.size(), 1);
        check("t6_w0", logw(0), 64'h0000010203040506);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
